popcount_acc_seq: RTL and testbench

Streaming, parametrised successor to the fixed 24-input approximate popcount cores. Accepts an N_IN-bit input word per beat over a valid/ready handshake and accumulates the popcount over N_BEATS beats. Emits the total and a threshold-compare bit for neuron activation. An optional per-beat LSB truncation provides controllable approximation. Sits between the sensor/feature buffer and the neuron activation logic of the printed NN datapath.

---
 rtl/popcount_pkg.sv | 21 ++
 rtl/popcount_core.sv | 18 +
 rtl/popcount_acc_seq.sv | 92 +++++++++
 tb/tb_popcount_acc_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// popcount_pkg: shared state encoding and width/mask helpers for the streaming popcount accumulator
package popcount_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    function automatic int cw_of(input int n_in);
        return $clog2(n_in + 1);
    endfunction

    function automatic int sw_of(input int n_in, input int n_beats);
        return $clog2(n_in * n_beats + 1);
    endfunction

    function automatic logic [31:0] trunc_mask(input int trunc);
        return ~((32'd1 << trunc) - 32'd1);
    endfunction

endpackage

// File: rtl/popcount_core.sv
// popcount_core: purely combinational exact popcount of one input word
module popcount_core
    import popcount_pkg::*;
#(
    parameter  int N_IN = 24,
    localparam int CW   = cw_of(N_IN)
) (
    input  logic [N_IN-1:0] in_data,
    output logic [CW-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_IN; i++)
            count = count + CW'(in_data[i]);
    end

endmodule

// File: rtl/popcount_acc_seq.sv
// popcount_acc_seq: accumulates (optionally LSB-truncated) popcounts over N_BEATS beats and compares against a threshold
module popcount_acc_seq
    import popcount_pkg::*;
#(
    parameter  int N_IN    = 24,
    parameter  int N_BEATS = 4,
    parameter  int TRUNC   = 0,
    localparam int CW      = cw_of(N_IN),
    localparam int SW      = sw_of(N_IN, N_BEATS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    input  logic [SW-1:0]   thr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_sum,
    output logic            out_act
);

    localparam int BW = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    state_t          state_q, state_d;
    logic [SW-1:0]   acc_q, acc_d, sum_q, sum_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic            act_q, act_d;
    logic [CW-1:0]   pc, pc_t;
    logic [SW-1:0]   acc_next;
    logic            in_fire, out_fire, last;

    popcount_core #(.N_IN(N_IN)) u_core (
        .in_data(in_data),
        .count  (pc)
    );

    // truncation is applied to each beat's count before it joins the running sum
    assign pc_t     = pc & CW'(trunc_mask(TRUNC));
    assign acc_next = acc_q + SW'(pc_t);
    assign in_ready = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign last     = (cnt_q == BW'(N_BEATS - 1));
    assign out_sum  = sum_q;
    assign out_act  = act_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        act_d   = act_q;
        if (flush) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == ACC) begin
            if (in_fire && last) begin
                state_d = DONE;
                sum_d   = acc_next;
                act_d   = (acc_next >= thr);
                acc_d   = '0;
                cnt_d   = '0;
            end else if (in_fire) begin
                acc_d = acc_next;
                cnt_d = cnt_q + BW'(1);
            end
        end else if (out_fire) begin
            state_d = ACC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            act_q   <= act_d;
        end
    end

endmodule

// File: tb/tb_popcount_acc_seq.sv
// tb_popcount_acc_seq: randomized self-checking bench for exact and truncated accumulator instances
module tb_popcount_acc_seq;
    import popcount_pkg::*;

    localparam int SW = sw_of(24, 4);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [23:0]   in_data = '0;
    logic [SW-1:0] thr = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, out_act;
    logic [SW-1:0] out_sum;
    logic          in_ready2, out_valid2, out_act2;
    logic [SW-1:0] out_sum2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    popcount_acc_seq #(.N_IN(24), .N_BEATS(4), .TRUNC(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .thr(thr), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_act(out_act)
    );

    popcount_acc_seq #(.N_IN(24), .N_BEATS(4), .TRUNC(2)) dut_t (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .thr(thr), .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_act(out_act2)
    );

    // reference: count set bits, then drop the low tr bits of that count
    function automatic int pcnt(input logic [23:0] d, input int tr);
        int c;
        c = $countones(d);
        return (c >> tr) << tr;
    endfunction

    task automatic feed(input logic [23:0] d[4], input logic [SW-1:0] t, input bit gaps, input string name);
        int e0, e1;
        e0 = 0;
        e1 = 0;
        thr = t;
        for (int i = 0; i < 4; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || in_ready2 !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s beat%0d ready: in_ready=%b/%b out_valid=%b expected 1/1/0", name, i, in_ready, in_ready2, out_valid);
            end
            e0 += pcnt(d[i], 0);
            e1 += pcnt(d[i], 2);
            in_valid = 1'b1;
            in_data = d[i];
            @(negedge clk);
            in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b1 || out_valid2 !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s valid: out_valid=%b/%b in_ready=%b expected 1/1/0", name, out_valid, out_valid2, in_ready);
        end
        checks++;
        if (out_sum !== SW'(e0) || out_act !== (e0 >= int'(t))) begin
            errors++;
            $display("FAIL %s exact: sum=%0d act=%b expected sum=%0d act=%b", name, out_sum, out_act, e0, e0 >= int'(t));
        end
        checks++;
        if (out_sum2 !== SW'(e1) || out_act2 !== (e1 >= int'(t))) begin
            errors++;
            $display("FAIL %s trunc: sum=%0d act=%b expected sum=%0d act=%b", name, out_sum2, out_act2, e1, e1 >= int'(t));
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL %s consume: out_valid=%b/%b in_ready=%b/%b expected 0/0/1/1", name, out_valid, out_valid2, in_ready, in_ready2);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_act !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b sum=%0d act=%b expected 1 0 0 0", in_ready, out_valid, out_sum, out_act);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        feed('{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, SW'(90), 1'b0, "all_ones");
        consume("all_ones");
    endtask

    task automatic test_sparse();
        feed('{24'h000001, 24'h000003, 24'h000000, 24'h800000}, SW'(5), 1'b0, "sparse");
        consume("sparse");
    endtask

    task automatic test_trunc();
        logic [23:0] d[4];
        for (int i = 0; i < 4; i++) begin
            d[i] = 24'hFFFFFF;
            d[i][$urandom_range(0, 23)] = 1'b0;
        end
        feed(d, SW'($urandom_range(70, 96)), 1'b1, "trunc23");
        consume("trunc23");
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] held;
        feed('{24'h0F0F0F, 24'h00FF00, 24'hAAAAAA, 24'h123456}, SW'(40), 1'b0, "bp");
        held = out_sum;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 24'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== held) begin
                errors++;
                $display("FAIL bp hold%0d: in_ready=%b out_valid=%b sum=%0d expected 0 1 %0d", i, in_ready, out_valid, out_sum, held);
            end
        end
        in_valid = 1'b0;
        consume("bp");
        feed('{24'h000007, 24'h000000, 24'h000001, 24'h000010}, SW'(5), 1'b0, "bp_next");
        consume("bp_next");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = 24'hFFFFFF;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        feed('{24'h00000F, 24'h00000F, 24'h00000F, 24'h00000F}, SW'(16), 1'b0, "flush");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_rst();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = 24'hFFFFFF;
            @(negedge clk);
        end
        in_data = 24'hFFFFFF;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_sum !== '0 || out_act !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum2 !== '0) begin
            errors++;
            $display("FAIL async_rst: sum=%0d/%0d act=%b out_valid=%b in_ready=%b expected 0/0 0 0 1", out_sum, out_sum2, out_act, out_valid, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        feed('{24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF}, SW'(33), 1'b0, "after_rst");
        consume("after_rst");
    endtask

    task automatic test_random();
        logic [23:0] d[4];
        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < 4; i++) d[i] = 24'($urandom);
            feed(d, SW'($urandom_range(0, 96)), 1'b1, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            consume("random");
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_sparse();
        test_trunc();
        test_backpressure();
        test_flush();
        test_async_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
